// File: rtl/arb_pkg.sv
// arb_pkg: shared types and sizes for the 8-requester grant arbiter.
//   N_REQ   number of requesters (fixed at 8)
//   ID_W    width of an encoded requester index
//   state_t arbiter FSM state {IDLE, BUSY}
//   grant_t one bit per requester
//   id_t    encoded requester index
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef logic [N_REQ-1:0] grant_t;
  typedef logic [ID_W-1:0]  id_t;
endpackage

// File: rtl/arb_prio_pick8.sv
// arb_prio_pick8: combinational circular priority picker.
// Search order is start, start-1, ... wrapping 0->7, so the first set bit
// met in that order wins. With start=7 it is a plain highest-bit-wins encoder.
//   vec    in  candidate request vector
//   start  in  index searched first
//   id     out encoded winner (0 when none)
//   onehot out one-hot winner (0 when none)
//   any    out some bit of vec is set
module arb_prio_pick8
  import arb_pkg::*;
(
  input  grant_t vec,
  input  id_t    start,
  output id_t    id,
  output grant_t onehot,
  output logic   any
);
  id_t idx;

  always_comb begin
    id     = '0;
    onehot = '0;
    any    = 1'b0;
    idx    = '0;
    // Walk the order backwards so the earliest hit in search order is the
    // last assignment and therefore wins.
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = start - id_t'(k);
      if (vec[idx]) begin
        id     = idx;
        onehot = grant_t'(1) << idx;
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/req_grant_arbiter8.sv
// req_grant_arbiter8: shares one resource between 8 requesters.
// Registered one-hot grant held while the owner keeps requesting; a tenure
// is cut after MAX_HOLD cycles (0 = unlimited), the cut owner is masked
// until it drops req for a cycle. No preemption of an active tenure.
// Build option: RR_ROTATE_EN selects round-robin instead of fixed priority
// (bit 7 highest).
//   clk       in  rising-edge clock
//   rst_n     in  synchronous active-low reset
//   req[7:0]  in  level request lines
//   gnt[7:0]  out one-hot registered grant, 0 when idle
//   gnt_id    out encoded owner, 0 when idle
//   gnt_valid out a grant is held
//   timeout   out one-cycle pulse when a tenure is cut by MAX_HOLD
module req_grant_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           state, state_n;
  grant_t           gnt_n, mask, mask_set, eff, pick_oh;
  id_t              id_n, pick_id, start;
  logic [CNT_W-1:0] hold_cnt, cnt_n;
  logic             to_n, pick_any;

  assign eff = req & ~mask;

`ifdef RR_ROTATE_EN
  id_t last_id;
  // Start just below the previous winner so it is searched last.
  assign start = last_id - id_t'(1);
`else
  assign start = id_t'(N_REQ-1);
`endif

  arb_prio_pick8 u_pick (
    .vec    (eff),
    .start  (start),
    .id     (pick_id),
    .onehot (pick_oh),
    .any    (pick_any)
  );

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    id_n     = gnt_id;
    cnt_n    = hold_cnt;
    to_n     = 1'b0;
    mask_set = '0;
    case (state)
      IDLE: begin
        gnt_n = '0;
        id_n  = '0;
        if (pick_any) begin
          gnt_n   = pick_oh;
          id_n    = pick_id;
          cnt_n   = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (!req[gnt_id]) begin
          gnt_n   = '0;
          id_n    = '0;
          state_n = IDLE;
        end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
          gnt_n            = '0;
          id_n             = '0;
          state_n          = IDLE;
          to_n             = 1'b1;
          mask_set[gnt_id] = 1'b1;
        end else if (hold_cnt != '1) begin
          cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
      mask     <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_id   <= id_n;
      hold_cnt <= cnt_n;
      timeout  <= to_n;
      // Clear on a sampled low req; a same-cycle set wins.
      mask     <= (mask & req) | mask_set;
    end
  end

`ifdef RR_ROTATE_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                      last_id <= '0;
    else if (state == IDLE && pick_any) last_id <= pick_id;
  end
`endif

  assign gnt_valid = (state == BUSY);
endmodule
